// File: rtl/intdiv_mulrec_if.sv
// Operand/result handshake bundle for the z*y+r reconstruction block.
// The master drives the operands and out_ready; the slave returns the result.
interface intdiv_mulrec_if #(parameter int N = 4);
  logic [N-1:0] z;
  logic [N-1:0] y;
  logic [N-1:0] r;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  modport master (output z, y, r, in_valid, out_ready,
                  input  in_ready, x, ovf, out_valid);
  modport slave  (input  z, y, r, in_valid, out_ready,
                  output in_ready, x, ovf, out_valid);
endinterface

// File: rtl/intdiv_mulrec.sv
// Rebuilds a divider's dividend as x = z*y + r with a serial shift-add multiply
// on magnitudes, then a sign fix-up and overflow check on a 2N+2-bit sum.
module intdiv_mulrec #(
  parameter int N = 4
) (
  input logic           clock,
  input logic           reset,
  intdiv_mulrec_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

  state_t         r_state;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N:0]     r_ay;
  logic           r_sgn;
  logic [N-1:0]   r_rem;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_x;
  logic           r_ovf;

  logic [N:0]     w_z_ext, w_y_ext, w_az, w_ay;
  logic [2*N+1:0] w_acc_ext, w_prod, w_sum;
  logic           w_ovf;

  // N+1-bit magnitudes so that -2^(N-1) stays exact
  assign w_z_ext = {bus.z[N-1], bus.z};
  assign w_y_ext = {bus.y[N-1], bus.y};
  assign w_az    = bus.z[N-1] ? -w_z_ext : w_z_ext;
  assign w_ay    = bus.y[N-1] ? -w_y_ext : w_y_ext;

  assign w_acc_ext = {2'b00, r_acc};
  assign w_prod    = r_sgn ? -w_acc_ext : w_acc_ext;
  assign w_sum     = w_prod + {{(N+2){r_rem[N-1]}}, r_rem};
  // representable iff every bit from the N-bit sign position upward agrees
  assign w_ovf     = !((&w_sum[2*N+1:N-1]) || !(|w_sum[2*N+1:N-1]));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_mcand <= {{(N-1){1'b0}}, w_az};
          r_ay    <= w_ay;
          r_sgn   <= bus.z[N-1] ^ bus.y[N-1];
          r_rem   <= bus.r;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= MUL;
        end
        MUL: begin
          // multiplicand shifts left one place per step, tracking the counter
          if (r_ay[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_ay    <= r_ay >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(N-1)) r_state <= FIX;
        end
        FIX: begin
          r_x     <= w_sum[N-1:0];
          r_ovf   <= w_ovf;
          r_state <= DONE;
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.x         = r_x;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_intdiv_mulrec.sv
// Directed and exhaustive checks of z*y+r reconstruction, handshake and reset.
module tb_intdiv_mulrec;
  localparam int N = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  intdiv_mulrec_if #(.N(N)) bus ();

  intdiv_mulrec #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation; garbage operands and in_valid pulses are driven while it runs.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input bit noise, output logic [3:0] ox, output logic oovf,
                        output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    bus.z = a; bus.y = b; bus.r = c; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.z = ~a; bus.y = ~b + 4'd3; bus.r = ~c;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (noise) bus.in_valid = ~bus.in_valid;
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    ox   = bus.x;
    oovf = bus.ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.z = '0; bus.y = '0; bus.r = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.x, bus.ovf} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b x=%h ovf=%b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.x, bus.ovf);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ox; logic oovf; int lat;
    run_op(4'd2, 4'd3, 4'd1, 1'b0, ox, oovf, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, required 5", lat);
    end
    checks++;
    if ({ox, oovf} !== {4'd7, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: x=%h ovf=%b, required 7 0", ox, oovf);
    end
    tick();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL basic_return: rdy=%b vld=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_signed();
    logic [3:0] ox; logic oovf; int lat;
    logic [3:0] tv [0:4][0:3];
    logic       tov [0:4];
    // z, y, r, expected x ; expected ovf
    tv[0] = '{4'hE, 4'h3, 4'hF, 4'h9}; tov[0] = 1'b0;  // -2*3-1 = -7
    tv[1] = '{4'h7, 4'h7, 4'h0, 4'h1}; tov[1] = 1'b1;  // 49
    tv[2] = '{4'h8, 4'hF, 4'h0, 4'h8}; tov[2] = 1'b1;  // 8
    tv[3] = '{4'h5, 4'h0, 4'hD, 4'hD}; tov[3] = 1'b0;  // y=0 -> r
    tv[4] = '{4'h8, 4'h0, 4'h7, 4'h7}; tov[4] = 1'b0;  // y=0 -> r
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i][0], tv[i][1], tv[i][2], i[0], ox, oovf, lat);
      checks++;
      if ({ox, oovf} !== {tv[i][3], tov[i]}) begin
        errors++;
        $display("FAIL signed_vec%0d: x=%h ovf=%b, required %h %b", i, ox, oovf, tv[i][3], tov[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ox; logic oovf; int lat; int bad; int extra;
    bus.out_ready = 1'b0;
    run_op(4'd1, 4'hF, 4'd0, 1'b0, ox, oovf, lat);
    checks++;
    if ({ox, oovf} !== {4'hF, 1'b0}) begin
      errors++;
      $display("FAIL bp_result: x=%h ovf=%b, required f 0", ox, oovf);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0]; bus.z = 4'd3; bus.y = 4'd3;
      tick();
      if ({bus.out_valid, bus.in_ready, bus.x, bus.ovf} !== {1'b1, 1'b0, 4'hF, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL bp_release: %0d cycles not idle, required 0", extra);
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] ox; logic oovf; int lat; int seen;
    bus.z = 4'd5; bus.y = 4'd5; bus.r = 4'd0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.x, bus.ovf} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset: rdy=%b vld=%b x=%h ovf=%b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.x, bus.ovf);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midop_ghost: out_valid high %0d cycles, required 0", seen);
    end
    run_op(4'd3, 4'd2, 4'd1, 1'b1, ox, oovf, lat);
    checks++;
    if ({ox, oovf} !== {4'd7, 1'b0}) begin
      errors++;
      $display("FAIL midop_next: x=%h ovf=%b, required 7 0", ox, oovf);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [3:0] ox; logic oovf; int lat;
    logic [31:0] pv; int p; logic exp_ovf;
    logic [3:0] tz, ty, tr;
    for (int zi = -8; zi < 8; zi++)
      for (int yi = -8; yi < 8; yi++)
        for (int ri = -8; ri < 8; ri++) begin
          tz = zi[3:0]; ty = yi[3:0]; tr = ri[3:0];
          p = zi * yi + ri;
          pv = p;
          exp_ovf = (p < -8) || (p > 7);
          run_op(tz, ty, tr, 1'b0, ox, oovf, lat);
          checks++;
          if ({ox, oovf, lat} !== {pv[3:0], exp_ovf, 32'd5}) begin
            errors++;
            $display("FAIL exh z=%0d y=%0d r=%0d: x=%h ovf=%b lat=%0d, required %h %b 5",
                     zi, yi, ri, ox, oovf, lat, pv[3:0], exp_ovf);
          end
          tick();
          checks++;
          if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL exh_single z=%0d y=%0d r=%0d: out_valid=%b, required 0",
                     zi, yi, ri, bus.out_valid);
          end
        end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_reset_midop();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
